mips_instr_rom_harness: RTL and testbench
=========================================

Name: mips_instr_rom_harness

Overview:
Parametrised instruction-memory model and run monitor for mips_cpu_harvard benches. It replaces per-test hard-coded address decoders.
- Word array, preloadable through a load port.
- Optional endian byte swap on read data.
- Configurable fetch wait states; the CPU is stalled through clk_enable while a fetch is pending.
- Sticky fault flag for bad fetches.
- Halt/timeout monitor that tells the bench when to print register_v0 and finish.

Parameters:
BASE_ADDR, 32'hBFC00000, byte address of word 0
DEPTH, 64, number of 32-bit words (power of 2, >=4)
WAIT_STATES, 0, extra cycles before fetch data is valid (0..15)
BYTE_SWAP, 1, 1 = instr_readdata is the stored word byte-reversed ({b0,b1,b2,b3})
HALT_ADDR, 32'h00000000, fetch address that signals program end
TIMEOUT_CYCLES, 200, cycles from reset release before timeout is flagged

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
load_en  in  1  preload write strobe
load_index  in  $clog2(DEPTH)  preload word index
load_word  in  32  preload data, stored unswapped
instr_address  in  32  CPU fetch byte address
cpu_active  in  1  CPU active output
instr_readdata  out  32  fetch data to CPU
instr_valid  out  1  fetch data valid; bench ties this to CPU clk_enable
fault  out  1  sticky: out-of-range or unaligned fetch seen
cycle_count  out  32  cycles since reset release, frozen at done/timeout
done  out  1  sticky: halt detected
timeout  out  1  sticky: TIMEOUT_CYCLES reached without done

Behaviour:
- Reset (reset=0) forces: instr_valid=0, fault=0, done=0, timeout=0, cycle_count=0, fetch FSM=WAIT with wait counter=WAIT_STATES, last_addr=32'hFFFFFFFF.
  - The memory array is not cleared; preloaded contents survive reset.
- Preload: on a posedge with load_en=1, mem[load_index] <= load_word. This is accepted in any state, including during a run.
- A same-cycle fetch of the index being written returns the old word; the new word is visible from the next cycle.
- Index computation: idx = (instr_address - BASE_ADDR) >> 2.
  - In range: instr_address[1:0]==0 and instr_address - BASE_ADDR < 4*DEPTH (unsigned).
  - Out of range or unaligned: instr_readdata=32'h00000000 (NOP) and fault is set at the next posedge while instr_valid=1.
  - A fetch of HALT_ADDR never sets fault.
- Fetch FSM (states READY, WAIT):
  - With WAIT_STATES=0, instr_readdata is combinational from the array, and instr_valid=1 from the first posedge after reset release.
  - With WAIT_STATES=N>0:
    - In READY, an instr_address different from last_addr drops instr_valid combinationally the same cycle. last_addr is updated and the FSM enters WAIT with counter=N.
    - In WAIT, instr_valid=0; the counter decrements each posedge; at counter==1 the FSM returns to READY, and instr_valid=1 on the following cycle.
    - An address change during WAIT restarts the counter at N.
  - instr_readdata always reflects the current instr_address; only instr_valid gates its use.
- Byte swap: when BYTE_SWAP=1, instr_readdata = {w[7:0], w[15:8], w[23:16], w[31:24]}; otherwise it is w.
- Monitor (states RUN, DONE, TIMEOUT):
  - In RUN, cycle_count increments every posedge.
  - If instr_address==HALT_ADDR and cpu_active==0 at a posedge, the monitor goes to DONE and sets done=1.
  - Otherwise, when cycle_count reaches TIMEOUT_CYCLES-1, the monitor goes to TIMEOUT and sets timeout=1.
  - If both conditions hold in the same cycle, done has priority and timeout stays 0.
  - DONE and TIMEOUT are terminal until reset, and cycle_count holds.
  - cycle_count saturates at 32'hFFFFFFFF.
- Reset asserted mid-fetch or mid-run returns every output to its reset value immediately (asynchronous).

Decomposition:
- Shared package mips_tb_pkg holds:
  - NOP_WORD = 32'h0000_0000
  - RESET_VECTOR = 32'hBFC00000
  - enum fetch_state_t {READY, WAIT}
  - enum mon_state_t {RUN, DONE, TIMEOUT}
  - function byte_swap32
- One sub-module, mips_run_monitor, holds the cycle counter, halt detect and timeout logic. The top module holds the array, index decode, byte swap and fetch FSM.

Test Plan:
1. BYTE_SWAP=1, WAIT_STATES=0. Preload mem[0]=32'h2484000B, mem[1]=32'h2882004D. instr_address=32'hBFC00000 -> instr_readdata=32'h0B008424, instr_valid=1. Address 32'hBFC00004 -> 32'h4D008228.
2. WAIT_STATES=3, address changes 32'hBFC00000 -> 32'hBFC00004. Required: instr_valid=0 for exactly 3 cycles, then 1. A second change during the wait restarts the count at 3.
3. Fetch 32'hBFC00002 (unaligned), then 32'hBFC00100 with DEPTH=64 (out of range). Required: instr_readdata=0 and fault=1 after the first posedge, staying 1. A later fetch of 32'h00000000 leaves fault unchanged.
4. Drive instr_address=0 with cpu_active=0 at cycle 10. Required: done=1, cycle_count frozen at 10, timeout=0 forever after.
5. Hold cpu_active=1 with TIMEOUT_CYCLES=20. Required: timeout=1 once cycle_count=19, done=0. Pulse reset low -> all flags 0 and cycle_count=0; mem[0] still reads 32'h0B008424.
6. load_en writes mem[0]=32'h00000008 while fetching 32'hBFC00000. Required: same cycle returns the old swapped word; the next cycle returns 32'h08000000.

Source files
------------

// File: rtl/mips_tb_pkg.sv
// rtl/mips_tb_pkg.sv - shared types and helpers for the instruction ROM harness
package mips_tb_pkg;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    typedef enum logic {
        READY,
        WAIT
    } fetch_state_t;

    typedef enum logic [1:0] {
        RUN,
        DONE,
        TIMEOUT
    } mon_state_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - cycle counter with halt detect and timeout flag
module mips_run_monitor
    import mips_tb_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_address,
    input  logic        cpu_active,
    output logic [31:0] cycle_count,
    output logic        done,
    output logic        timeout
);

    localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

    mon_state_t mon_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_state   <= RUN;
            cycle_count <= 32'd0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (mon_state)
                RUN: begin
                    // Halt wins over timeout; the counter freezes on the terminal edge.
                    if (instr_address == HALT_ADDR && !cpu_active) begin
                        mon_state <= DONE;
                        done      <= 1'b1;
                    end else if (cycle_count == LAST_CYCLE) begin
                        mon_state <= TIMEOUT;
                        timeout   <= 1'b1;
                    end else if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                DONE:    mon_state <= DONE;
                TIMEOUT: mon_state <= TIMEOUT;
                default: mon_state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/mips_instr_rom_harness.sv
// rtl/mips_instr_rom_harness.sv - preloadable instruction memory with wait states and run monitor
module mips_instr_rom_harness
    import mips_tb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = RESET_VECTOR,
    parameter int          DEPTH          = 64,
    parameter int          WAIT_STATES    = 0,
    parameter int          BYTE_SWAP      = 1,
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 200
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_index,
    input  logic [31:0]              load_word,
    input  logic [31:0]              instr_address,
    input  logic                     cpu_active,
    output logic [31:0]              instr_readdata,
    output logic                     instr_valid,
    output logic                     fault,
    output logic [31:0]              cycle_count,
    output logic                     done,
    output logic                     timeout
);

    localparam int          IW     = $clog2(DEPTH);
    localparam logic [3:0]  WS     = 4'(WAIT_STATES);
    localparam logic [31:0] SPAN   = 32'(4 * DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset;
    logic          in_range;
    logic [IW-1:0] idx;
    logic [31:0]   word;

    fetch_state_t  fetch_state;
    logic [3:0]    wait_cnt;
    logic [31:0]   last_addr;
    logic          valid_q;

    assign offset   = instr_address - BASE_ADDR;
    assign in_range = (instr_address[1:0] == 2'b00) && (offset < SPAN);
    assign idx      = offset[IW+1:2];
    assign word     = in_range ? mem[idx] : NOP_WORD;

    assign instr_readdata = (BYTE_SWAP != 0) ? byte_swap32(word) : word;

    // Combinational drop on an address change so the CPU never samples stale data.
    assign instr_valid = (WAIT_STATES == 0) ? valid_q
                       : (fetch_state == READY) && (instr_address == last_addr);

    // Array is deliberately left out of reset so preloads survive a reset pulse.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_index] <= load_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_state <= WAIT;
            wait_cnt    <= WS;
            last_addr   <= 32'hFFFF_FFFF;
            valid_q     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (instr_valid && !in_range && instr_address != HALT_ADDR) begin
                fault <= 1'b1;
            end
            if (instr_address != last_addr) begin
                fetch_state <= WAIT;
                wait_cnt    <= WS;
                last_addr   <= instr_address;
            end else if (fetch_state == WAIT) begin
                if (wait_cnt <= 4'd1) begin
                    fetch_state <= READY;
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
            end
        end
    end

    mips_run_monitor #(
        .HALT_ADDR      (HALT_ADDR),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_monitor (
        .clk           (clk),
        .rst_n         (reset),
        .instr_address (instr_address),
        .cpu_active    (cpu_active),
        .cycle_count   (cycle_count),
        .done          (done),
        .timeout       (timeout)
    );

endmodule

// File: tb/tb_mips_instr_rom_harness.sv
// tb/tb_mips_instr_rom_harness.sv - directed self-checking bench for mips_instr_rom_harness
module tb_mips_instr_rom_harness;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [5:0]  load_index;
    logic [31:0] load_word;
    logic [31:0] addr0, addr1;
    logic        cpu_active;

    logic [31:0] rd0, cc0, rd1, cc1;
    logic        v0, f0, d0, t0, v1, f1, d1, t1;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    mips_instr_rom_harness #(
        .WAIT_STATES    (0),
        .TIMEOUT_CYCLES (20)
    ) u0 (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_index     (load_index),
        .load_word      (load_word),
        .instr_address  (addr0),
        .cpu_active     (cpu_active),
        .instr_readdata (rd0),
        .instr_valid    (v0),
        .fault          (f0),
        .cycle_count    (cc0),
        .done           (d0),
        .timeout        (t0)
    );

    mips_instr_rom_harness #(
        .WAIT_STATES (3)
    ) u1 (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_index     (load_index),
        .load_word      (load_word),
        .instr_address  (addr1),
        .cpu_active     (cpu_active),
        .instr_readdata (rd1),
        .instr_valid    (v1),
        .fault          (f1),
        .cycle_count    (cc1),
        .done           (d1),
        .timeout        (t1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        load_en    = 1'b0;
        load_index = 6'd0;
        load_word  = 32'd0;
        addr0      = 32'hBFC0_0000;
        addr1      = 32'hBFC0_0000;
        cpu_active = 1'b1;
        tick;
        tick;

        check("rst_valid0", {31'd0, v0}, 32'd0);
        check("rst_valid1", {31'd0, v1}, 32'd0);
        check("rst_fault", {31'd0, f0}, 32'd0);
        check("rst_done", {31'd0, d0}, 32'd0);
        check("rst_timeout", {31'd0, t0}, 32'd0);
        check("rst_count", cc0, 32'd0);

        load_en    = 1'b1;
        load_index = 6'd0;
        load_word  = 32'h2484_000B;
        tick;
        load_index = 6'd1;
        load_word  = 32'h2882_004D;
        tick;
        load_en    = 1'b0;

        // Fetch with no wait states
        reset = 1'b1;
        tick;
        check("t1_valid", {31'd0, v0}, 32'd1);
        check("t1_word0", rd0, 32'h0B00_8424);
        check("t1_count", cc0, 32'd1);
        addr0 = 32'hBFC0_0004;
        #1;
        check("t1_word1", rd0, 32'h4D00_8228);
        check("t1_valid_w1", {31'd0, v0}, 32'd1);

        // Three wait states
        n = 0;
        while (!v1 && n < 10) begin
            tick;
            n++;
        end
        check("t2_ready", {31'd0, v1}, 32'd1);
        check("t2_word0", rd1, 32'h0B00_8424);
        addr1 = 32'hBFC0_0004;
        #1;
        check("t2_drop", {31'd0, v1}, 32'd0);
        check("t2_data_follows", rd1, 32'h4D00_8228);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t2_wait", {31'd0, v1}, 32'd0);
        end
        tick;
        check("t2_valid_again", {31'd0, v1}, 32'd1);

        addr1 = 32'hBFC0_0000;
        #1;
        check("t2_drop2", {31'd0, v1}, 32'd0);
        tick;
        tick;
        addr1 = 32'hBFC0_0004;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t2_restart_wait", {31'd0, v1}, 32'd0);
        end
        tick;
        check("t2_restart_valid", {31'd0, v1}, 32'd1);

        addr1 = 32'h0000_0000;
        repeat (5) tick;
        check("t2_halt_valid", {31'd0, v1}, 32'd1);
        check("t2_halt_nofault", {31'd0, f1}, 32'd0);
        check("t2_halt_nop", rd1, 32'd0);

        // Bad fetches
        check("t3_fault_pre", {31'd0, f0}, 32'd0);
        addr0 = 32'hBFC0_0002;
        #1;
        check("t3_unaligned_nop", rd0, 32'd0);
        tick;
        check("t3_fault_set", {31'd0, f0}, 32'd1);
        addr0 = 32'hBFC0_0100;
        #1;
        check("t3_oor_nop", rd0, 32'd0);
        tick;
        check("t3_fault_held", {31'd0, f0}, 32'd1);
        addr0 = 32'h0000_0000;
        tick;
        tick;
        check("t3_fault_halt", {31'd0, f0}, 32'd1);

        // Timeout
        n = 0;
        while (!t0 && n < 40) begin
            tick;
            n++;
        end
        check("t5_timeout", {31'd0, t0}, 32'd1);
        check("t5_count", cc0, 32'd19);
        check("t5_nodone", {31'd0, d0}, 32'd0);
        repeat (3) tick;
        check("t5_count_frozen", cc0, 32'd19);
        check("t5_timeout_held", {31'd0, t0}, 32'd1);

        reset = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, v0}, 32'd0);
        check("t5_rst_fault", {31'd0, f0}, 32'd0);
        check("t5_rst_timeout", {31'd0, t0}, 32'd0);
        check("t5_rst_done", {31'd0, d0}, 32'd0);
        check("t5_rst_count", cc0, 32'd0);
        addr0 = 32'hBFC0_0000;
        #1;
        check("t5_mem_kept", rd0, 32'h0B00_8424);
        tick;
        reset = 1'b1;
        tick;
        check("t5_valid_after", {31'd0, v0}, 32'd1);

        // Preload during fetch
        load_en    = 1'b1;
        load_index = 6'd0;
        load_word  = 32'h0000_0008;
        #1;
        check("t6_old_word", rd0, 32'h0B00_8424);
        tick;
        load_en = 1'b0;
        check("t6_new_word", rd0, 32'h0800_0000);

        // Halt detect
        n = 0;
        while (cc0 != 32'd10 && n < 30) begin
            tick;
            n++;
        end
        check("t4_reach10", cc0, 32'd10);
        addr0      = 32'h0000_0000;
        cpu_active = 1'b0;
        tick;
        check("t4_done", {31'd0, d0}, 32'd1);
        check("t4_count", cc0, 32'd10);
        check("t4_notimeout", {31'd0, t0}, 32'd0);
        repeat (25) tick;
        check("t4_done_held", {31'd0, d0}, 32'd1);
        check("t4_notimeout_late", {31'd0, t0}, 32'd0);
        check("t4_count_frozen", cc0, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
